// File: rtl/frame_bbox_scan.sv
// Scans one stored frame through the shared RAM read port, thresholds each pixel
// and publishes the bounding box and hit count of the bright region.
module frame_bbox_scan #(
    parameter int unsigned H_RES  = 256,
    parameter int unsigned V_RES  = 240,
    parameter int unsigned XW     = 8,
    parameter int unsigned YW     = 8,
    parameter int unsigned RD_LAT = 2,
    parameter logic [2:0]  THRESH = 3'd4
) (
    input  logic          sysclk,
    input  logic          resetc,
    input  logic          start,
    output logic [15:0]   rdaddress,
    output logic          rdclock,
    output logic          rden,
    input  logic [2:0]    data,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [XW-1:0] xmin,
    output logic [XW-1:0] xmax,
    output logic [YW-1:0] ymin,
    output logic [YW-1:0] ymax,
    output logic [16:0]   count
);

    localparam int unsigned   N         = H_RES * V_RES;
    localparam logic [15:0]   LAST_ADDR = 16'(N - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(H_RES - 1);
    localparam logic [2:0]    DRAIN_END = 3'(RD_LAT - 1);
    localparam int unsigned   XPW       = RD_LAT * XW;
    localparam int unsigned   YPW       = RD_LAT * YW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic            issue;
    logic            scan_start;
    logic            last_issue;
    logic [2:0]      drain_cnt;
    logic [15:0]     addr_cnt;
    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;

    // Tag pipeline: bit/field 0 is the address issued this cycle, the top entry
    // lines up with the data word arriving from the RAM.
    logic [RD_LAT-1:0] vld_pipe;
    logic [XPW-1:0]    x_pipe;
    logic [YPW-1:0]    y_pipe;

    logic            tag_vld;
    logic [XW-1:0]   tag_x;
    logic [YW-1:0]   tag_y;
    logic            hit;

    logic            s_found;
    logic [XW-1:0]   s_xmin, s_xmax;
    logic [YW-1:0]   s_ymin, s_ymax;
    logic [16:0]     s_count;

    assign rdclock = sysclk;
    assign rden    = vld_pipe[0];
    assign busy    = (state != S_IDLE);

    assign tag_vld = vld_pipe[RD_LAT-1];
    assign tag_x   = x_pipe[XPW-1 -: XW];
    assign tag_y   = y_pipe[YPW-1 -: YW];
    assign hit     = tag_vld && (data >= THRESH);

    assign last_issue = issue && (addr_cnt == LAST_ADDR);

    always_comb begin
        state_nxt  = state;
        scan_start = 1'b0;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    scan_start = 1'b1;
                    issue      = 1'b1;
                    state_nxt  = S_SCAN;
                end
            end
            S_SCAN: begin
                issue = 1'b1;
                if (addr_cnt == LAST_ADDR) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_END) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge resetc) begin
        if (!resetc) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 3'd1 : '0;
        end
    end

    // Counters return to zero on the final issue so the next scan starts clean.
    always_ff @(posedge sysclk or negedge resetc) begin
        if (!resetc) begin
            addr_cnt  <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            rdaddress <= '0;
        end else begin
            if (issue) rdaddress <= addr_cnt;
            if (last_issue) begin
                addr_cnt <= '0;
                x_cnt    <= '0;
                y_cnt    <= '0;
            end else if (issue) begin
                addr_cnt <= addr_cnt + 16'd1;
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + YW'(1);
                end else begin
                    x_cnt <= x_cnt + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge sysclk or negedge resetc) begin
        if (!resetc) begin
            vld_pipe <= '0;
            x_pipe   <= '0;
            y_pipe   <= '0;
        end else begin
            vld_pipe <= RD_LAT'({vld_pipe, issue});
            x_pipe   <= XPW'({x_pipe, x_cnt});
            y_pipe   <= YPW'({y_pipe, y_cnt});
        end
    end

    always_ff @(posedge sysclk or negedge resetc) begin
        if (!resetc) begin
            s_found <= 1'b0;
            s_xmin  <= '0;
            s_xmax  <= '0;
            s_ymin  <= '0;
            s_ymax  <= '0;
            s_count <= '0;
        end else if (scan_start) begin
            s_found <= 1'b0;
            s_xmin  <= '0;
            s_xmax  <= '0;
            s_ymin  <= '0;
            s_ymax  <= '0;
            s_count <= '0;
        end else if (hit) begin
            s_found <= 1'b1;
            s_count <= s_count + 17'd1;
            if (!s_found) begin
                s_xmin <= tag_x;
                s_xmax <= tag_x;
                s_ymin <= tag_y;
                s_ymax <= tag_y;
            end else begin
                if (tag_x < s_xmin) s_xmin <= tag_x;
                if (tag_x > s_xmax) s_xmax <= tag_x;
                if (tag_y < s_ymin) s_ymin <= tag_y;
                if (tag_y > s_ymax) s_ymax <= tag_y;
            end
        end
    end

    always_ff @(posedge sysclk or negedge resetc) begin
        if (!resetc) begin
            done  <= 1'b0;
            found <= 1'b0;
            xmin  <= '0;
            xmax  <= '0;
            ymin  <= '0;
            ymax  <= '0;
            count <= '0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_DONE) begin
                found <= s_found;
                xmin  <= s_xmin;
                xmax  <= s_xmax;
                ymin  <= s_ymin;
                ymax  <= s_ymax;
                count <= s_count;
            end
        end
    end

endmodule

// File: tb/tb_frame_bbox_scan.sv
// Drives three scanners (read latency 1, 2, 4) from one frame store and checks
// each against a bounding-box reference computed directly from the frame.
module tb_frame_bbox_scan;

    localparam int unsigned H_RES = 16;
    localparam int unsigned V_RES = 12;
    localparam int unsigned XW    = 4;
    localparam int unsigned YW    = 4;
    localparam int unsigned N     = H_RES * V_RES;
    localparam int unsigned NI    = 3;
    localparam int unsigned LATS [NI] = '{1, 2, 4};
    localparam logic [2:0]  THRESH = 3'd4;

    logic clk = 1'b0;
    logic resetc;
    logic start;

    logic [15:0]   rdaddress_v [NI];
    logic          rdclock_v   [NI];
    logic          rden_v      [NI];
    logic          busy_v      [NI];
    logic          done_v      [NI];
    logic          found_v     [NI];
    logic [XW-1:0] xmin_v      [NI];
    logic [XW-1:0] xmax_v      [NI];
    logic [YW-1:0] ymin_v      [NI];
    logic [YW-1:0] ymax_v      [NI];
    logic [16:0]   count_v     [NI];

    logic [2:0] mem [65536];

    int n_checks = 0;
    int n_pass   = 0;
    int ref_found, ref_count, ref_xmin, ref_xmax, ref_ymin, ref_ymax;

    always #5 clk = ~clk;

    for (genvar g = 0; g < int'(NI); g++) begin : g_dut
        localparam int unsigned LAT = LATS[g];
        localparam int unsigned PI  = (LAT > 1) ? LAT - 2 : 0;
        logic [15:0] a_hist [4];
        logic        v_hist [4];
        logic [2:0]  ram_q;

        // Reads outside a valid request return a bright value on purpose.
        always @(posedge clk) begin
            a_hist[0] <= rdaddress_v[g];
            v_hist[0] <= rden_v[g];
            for (int j = 1; j < 4; j++) begin
                a_hist[j] <= a_hist[j-1];
                v_hist[j] <= v_hist[j-1];
            end
        end

        assign ram_q = (LAT == 1) ? (rden_v[g] ? mem[rdaddress_v[g]] : 3'd7)
                                  : (v_hist[PI] ? mem[a_hist[PI]] : 3'd7);

        frame_bbox_scan #(
            .H_RES (H_RES),
            .V_RES (V_RES),
            .XW    (XW),
            .YW    (YW),
            .RD_LAT(LAT),
            .THRESH(THRESH)
        ) u_dut (
            .sysclk   (clk),
            .resetc   (resetc),
            .start    (start),
            .rdaddress(rdaddress_v[g]),
            .rdclock  (rdclock_v[g]),
            .rden     (rden_v[g]),
            .data     (ram_q),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .found    (found_v[g]),
            .xmin     (xmin_v[g]),
            .xmax     (xmax_v[g]),
            .ymin     (ymin_v[g]),
            .ymax     (ymax_v[g]),
            .count    (count_v[g])
        );
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic fill_const(input logic [2:0] v);
        for (int a = 0; a < int'(N); a++) mem[16'(a)] = v;
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int a = 0; a < int'(N); a++) mem[16'(a)] = 3'($urandom_range(hi, lo));
    endtask

    task automatic set_px(input int x, input int y, input logic [2:0] v);
        mem[16'(y * int'(H_RES) + x)] = v;
    endtask

    task automatic fill_sparse(input int hits);
        fill_rand(0, 3);
        for (int i = 0; i < hits; i++)
            set_px(int'($urandom_range(H_RES - 1, 0)), int'($urandom_range(V_RES - 1, 0)),
                   3'($urandom_range(7, 4)));
    endtask

    // Reference: scan the stored frame as a 2-D image.
    task automatic model_frame();
        int x, y;
        ref_found = 0; ref_count = 0;
        ref_xmin = 0; ref_xmax = 0; ref_ymin = 0; ref_ymax = 0;
        for (int a = 0; a < int'(N); a++) begin
            if (mem[16'(a)] >= THRESH) begin
                x = a % int'(H_RES);
                y = a / int'(H_RES);
                if (ref_found == 0) begin
                    ref_xmin = x; ref_xmax = x; ref_ymin = y; ref_ymax = y;
                end else begin
                    if (x < ref_xmin) ref_xmin = x;
                    if (x > ref_xmax) ref_xmax = x;
                    if (y < ref_ymin) ref_ymin = y;
                    if (y > ref_ymax) ref_ymax = y;
                end
                ref_found = 1;
                ref_count++;
            end
        end
    endtask

    task automatic check_results(input int g, input string name);
        string t;
        t = $sformatf("%s.L%0d", name, LATS[g]);
        check({t, ".found"}, int'(found_v[g]), ref_found);
        check({t, ".count"}, int'(count_v[g]), ref_count);
        check({t, ".xmin"},  int'(xmin_v[g]),  ref_xmin);
        check({t, ".xmax"},  int'(xmax_v[g]),  ref_xmax);
        check({t, ".ymin"},  int'(ymin_v[g]),  ref_ymin);
        check({t, ".ymax"},  int'(ymax_v[g]),  ref_ymax);
    endtask

    task automatic check_zero(input int g, input string name);
        string t;
        t = $sformatf("%s.L%0d", name, LATS[g]);
        check({t, ".busy"},  int'(busy_v[g]),  0);
        check({t, ".rden"},  int'(rden_v[g]),  0);
        check({t, ".done"},  int'(done_v[g]),  0);
        check({t, ".rdaddr"}, int'(rdaddress_v[g]), 0);
        check({t, ".found"}, int'(found_v[g]), 0);
        check({t, ".count"}, int'(count_v[g]), 0);
        check({t, ".bbox"},
              int'(xmin_v[g]) | int'(xmax_v[g]) | int'(ymin_v[g]) | int'(ymax_v[g]), 0);
    endtask

    task automatic wait_idle(input string name);
        int idle;
        idle = 0;
        for (int c = 0; c < 4 * int'(N) && idle == 0; c++) begin
            @(posedge clk); #1;
            idle = 1;
            for (int g = 0; g < int'(NI); g++) if (busy_v[g]) idle = 0;
        end
        check({name, ".idle"}, idle, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // One scan from IDLE; optional second start pulse at offset extra_at.
    task automatic run_scan(input string name, input int extra_at);
        int done_at [NI];
        int done_cnt[NI];
        int addr_err[NI];
        int busy_err[NI];
        int lat;
        string t;
        model_frame();
        for (int g = 0; g < int'(NI); g++) begin
            done_at[g] = -1; done_cnt[g] = 0; addr_err[g] = 0; busy_err[g] = 0;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < int'(N) + 150; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            for (int g = 0; g < int'(NI); g++) begin
                lat = int'(LATS[g]);
                if (c < int'(N)) begin
                    if (!rden_v[g] || int'(rdaddress_v[g]) != c) addr_err[g]++;
                end else if (rden_v[g] || int'(rdaddress_v[g]) != int'(N) - 1) begin
                    addr_err[g]++;
                end
                if (busy_v[g] != (c < int'(N) + lat)) busy_err[g]++;
                if (done_v[g]) begin
                    if (done_cnt[g] == 0) done_at[g] = c;
                    done_cnt[g]++;
                end
                if (c == int'(H_RES) - 1 || c == int'(H_RES))
                    check($sformatf("%s.wrap_addr.L%0d", name, lat), int'(rdaddress_v[g]), c);
            end
            if (c == extra_at) start = 1'b1;
            else if (c == extra_at + 1) start = 1'b0;
        end
        for (int g = 0; g < int'(NI); g++) begin
            lat = int'(LATS[g]);
            t = $sformatf("%s.L%0d", name, lat);
            check({t, ".done_at"},  done_at[g],  int'(N) + lat);
            check({t, ".done_cnt"}, done_cnt[g], 1);
            check({t, ".addr_seq"}, addr_err[g], 0);
            check({t, ".busy_win"}, busy_err[g], 0);
            check_results(g, name);
        end
    endtask

    task automatic run_back_to_back();
        int first [NI];
        int second[NI];
        int low   [NI];
        int lat;
        string t;
        model_frame();
        for (int g = 0; g < int'(NI); g++) begin
            first[g] = -1; second[g] = -1; low[g] = 0;
        end
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 2 * (int'(N) + 4) + 6; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            for (int g = 0; g < int'(NI); g++) begin
                if (done_v[g]) begin
                    if (first[g] < 0) first[g] = c;
                    else if (second[g] < 0) second[g] = c;
                end
                if (!busy_v[g] && second[g] < 0) low[g]++;
            end
        end
        for (int g = 0; g < int'(NI); g++) begin
            lat = int'(LATS[g]);
            t = $sformatf("b2b.L%0d", lat);
            check({t, ".first_done"}, first[g], int'(N) + lat);
            check({t, ".gap"}, second[g] - first[g], int'(N) + lat + 1);
            check({t, ".busy_low"}, low[g], 1);
            check_results(g, "b2b");
        end
        start = 1'b0;
        wait_idle("b2b_drain");
    endtask

    initial begin
        resetc = 1'b0;
        start  = 1'b0;
        fill_const(3'd0);
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < int'(NI); g++) check_zero(g, "reset");
        resetc = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < int'(NI); g++) begin
            check_zero(g, "post_reset");
            check($sformatf("rdclock.L%0d", LATS[g]), int'(rdclock_v[g]), int'(clk));
        end

        fill_const(3'd0);
        set_px(5, 7, 3'd7);
        run_scan("single_hit", -1);
        wait_idle("single_hit");

        fill_const(3'd3);
        run_scan("all_below", -1);
        wait_idle("all_below");

        fill_const(3'd4);
        run_scan("all_at_thresh", -1);
        wait_idle("all_at_thresh");

        fill_rand(0, 3);
        set_px(int'(H_RES) - 1, 0, 3'd4);
        set_px(0, 1, 3'd5);
        set_px(0, int'(V_RES) - 1, 3'd6);
        run_scan("corners", -1);
        wait_idle("corners");

        for (int i = 0; i < 3; i++) begin
            fill_sparse(int'($urandom_range(6, 1)));
            run_scan($sformatf("sparse%0d", i), -1);
            wait_idle("sparse");
        end

        fill_rand(0, 7);
        run_scan("start_in_busy", 100);
        wait_idle("start_in_busy");

        fill_rand(0, 7);
        run_back_to_back();

        fill_rand(0, 7);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #3;
        resetc = 1'b0;
        #1;
        for (int g = 0; g < int'(NI); g++) check_zero(g, "mid_reset");
        @(posedge clk); #1;
        resetc = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < int'(NI); g++) check_zero(g, "after_release");
        fill_sparse(4);
        run_scan("after_reset", -1);
        wait_idle("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
